// File: rtl/retire_trace_unit.sv
// Retirement tracer: follows each fetched instruction through the four
// pipeline stages and logs every real instruction that reaches write-back
// into a first-word-fall-through FIFO. The FIFO drains over a valid/ready port.
module retire_trace_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int BP_MARGIN  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic [XLEN-1:0] if_inst_i,
  input  logic            flush_i,
  input  logic            hazard_stall_i,
  output logic            trace_valid_o,
  input  logic            trace_ready_i,
  output logic [XLEN-1:0] trace_pc_o,
  output logic [XLEN-1:0] trace_inst_o,
  output logic            trace_halt_o,
  output logic [31:0]     retire_count_o,
  output logic            halted_o,
  output logic            overflow_o,
  output logic            backpressure_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] BP_CNT   = (AW+1)'(FIFO_DEPTH - BP_MARGIN);

  // Stage shadow registers; index 0 is stage 1, index 3 is stage 4.
  logic [XLEN-1:0] r_stg_pc   [4];
  logic [XLEN-1:0] r_stg_inst [4];
  logic [3:0]      r_stg_v;

  // Trace FIFO storage and pointers (extra wrap bit tells full from empty).
  logic [XLEN-1:0] r_mem_pc   [FIFO_DEPTH];
  logic [XLEN-1:0] r_mem_inst [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [31:0]     r_retire_count;
  logic            r_halted;
  logic            r_overflow;

  logic [AW:0]     w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push_req;
  logic            w_push;
  logic            w_drop;
  logic            w_s4_halt;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_count == FULL_CNT);
  assign w_empty    = (w_count == '0);
  assign w_pop      = ~w_empty & trace_ready_i;
  // A record leaves stage 4 only when the pipeline advances; after halt
  // nothing more is logged at all.
  assign w_push_req = start_i & r_stg_v[3] & ~r_halted;
  // A full FIFO still accepts the record if the head leaves on the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_s4_halt  = (r_stg_inst[3] == '0);

  // Shift the stage shadows in lockstep with the CPU pipeline registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_stg_v <= '0;
    end else if (start_i) begin
      r_stg_pc[0]   <= if_pc_i;
      r_stg_inst[0] <= if_inst_i;
      r_stg_v[0]    <= ~flush_i;
      // A load-use stall turns the stage-1 entry into a bubble as it moves on.
      r_stg_v[1]    <= r_stg_v[0] & ~hazard_stall_i;
      r_stg_v[2]    <= r_stg_v[1];
      r_stg_v[3]    <= r_stg_v[2];
      for (int k = 1; k < 4; k++) begin
        r_stg_pc[k]   <= r_stg_pc[k-1];
        r_stg_inst[k] <= r_stg_inst[k-1];
      end
    end
  end

  // Write the retiring record into the FIFO slot at the write pointer.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr[AW-1:0]]   <= r_stg_pc[3];
      r_mem_inst[r_wr_ptr[AW-1:0]] <= r_stg_inst[3];
    end
  end

  // Pointer, retirement counter and sticky status bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_retire_count <= '0;
      r_halted       <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr       <= r_wr_ptr + PTR_ONE;
        r_retire_count <= r_retire_count + 32'd1;
        if (w_s4_halt) begin
          r_halted <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head of the FIFO is visible without an extra read cycle.
  assign trace_valid_o  = ~w_empty;
  assign trace_pc_o     = r_mem_pc[r_rd_ptr[AW-1:0]];
  assign trace_inst_o   = r_mem_inst[r_rd_ptr[AW-1:0]];
  assign trace_halt_o   = (trace_inst_o == '0) & trace_valid_o;
  assign retire_count_o = r_retire_count;
  assign halted_o       = r_halted;
  assign overflow_o     = r_overflow;
  assign backpressure_o = (w_count >= BP_CNT);

endmodule
